hex_display_sched: RTL
======================

// Module: hex_display_sched
//
// PURPOSE
//   Shares the 4-digit hex display among N_REQ requesters (UART rx byte log, status, debug).
//   Accepts 16-bit display words over valid/ready and keeps each on screen for a fixed dwell time.
//   Grants the display round-robin.
//   Sits between the producers and the hex display driver; o_data feeds the driver's i_data.
//
// PARAMETERS
//   N_REQ         2          number of requesters, legal 1..8
//   DWELL_W       24         width of the dwell counter
//   DWELL_CYCLES  5_000_000  clk cycles a granted word stays shown, legal 1..2**DWELL_W-1
//   IDLE_VALUE    16'h0000   o_data value after reset
//
// PORTS
//   clk          in   1         system clock, all logic on posedge
//   rst          in   1         reset, asynchronous, active-high
//   i_req_valid  in   N_REQ     per-requester valid
//   i_req_data   in   16*N_REQ  requester k word at [16k+15:16k]
//   o_req_ready  out  N_REQ     one-hot grant/ready, combinational
//   i_hold       in   1         freeze: stop dwell count, block new grants
//   o_data       out  16        word to the display driver, registered
//   o_owner      out  OWN_W     index of the last accepted requester; OWN_W = max(1,clog2(N_REQ))
//   o_busy       out  1         1 while a dwell is in progress
//
// BEHAVIOUR
//   - Reset (rst high, async):
//       o_data=IDLE_VALUE, o_owner=0, o_busy=0, state IDLE, dwell cnt=0, rr pointer=0.
//       o_req_ready is forced 0 while rst is high.
//   - States:
//       IDLE: nothing shown under dwell.
//       SHOW: dwell cnt counts down from DWELL_CYCLES-1.
//   - Grant window: open = ~rst & ~i_hold & (state==IDLE | (state==SHOW & cnt==0)).
//   - When the window is open, the round-robin winner among the valid requesters gets o_req_ready=1.
//       Search starts at the rr pointer.
//       All other ready bits are 0.
//       If no valid requester, all ready bits are 0.
//   - Transfer = i_req_valid[k] & o_req_ready[k]. On the next edge:
//       o_data  <= word k
//       o_owner <= k
//       cnt     <= DWELL_CYCLES-1
//       state   <= SHOW, o_busy <= 1
//       rr pointer <= (k+1) mod N_REQ
//   - Latency: accepted word appears on o_data one cycle after the transfer cycle.
//   - Dwell: in SHOW with ~i_hold, cnt decrements each cycle.
//       At cnt==0 with no transfer, next state is IDLE and o_busy goes 0.
//       At cnt==0 with a transfer, the next word loads back-to-back with no IDLE cycle.
//       Each word is therefore shown exactly DWELL_CYCLES cycles plus any held cycles.
//   - i_hold=1: cnt, state and pointer are frozen and no grants are issued.
//       o_data is unchanged.
//       Holding in IDLE simply delays acceptance.
//   - o_data keeps the last word after the dwell ends; the display never blanks on idle.
//   - Requester rules:
//       A requester may drop valid before ready with no effect.
//       Data must be stable while valid is high.
//       The scheduler samples data only in the transfer cycle.
//   - Fairness: a continuously valid requester waits at most (N_REQ-1) dwell periods.
//   - N_REQ=1: pointer stays 0 and requester 0 always wins.
//   - Reset mid-SHOW aborts the dwell immediately and restores the reset values.
//
// STRUCTURE
//   - hex_display_defs.vh (shared include):
//       DATA_W=16
//       state encodings ST_IDLE=1'b0, ST_SHOW=1'b1
//       OWN_W computation macro
//   - Sub-module rr_arbiter #(N): inputs req[N], ptr, en; outputs one-hot gnt[N], gnt_idx.
//       Purely combinational; the scheduler owns the pointer register.
//   - Top: state/counter/data registers, data mux on gnt_idx.
//
// TESTING  (bench runs DWELL_CYCLES=4, N_REQ=2 unless noted)
//   1. rst pulse, all inputs 0 -> o_data=16'h0000, o_busy=0, o_req_ready=2'b00; ready stays 0 while rst=1 even with valid=2'b11.
//   2. req0 valid with 16'h1234 in IDLE -> o_req_ready=2'b01 same cycle; o_data=16'h1234 next edge; o_busy=1 for 4 cycles, then 0; o_data holds 16'h1234.
//   3. both valid continuously, words 16'hAAAA / 16'hBBBB -> o_data alternates AAAA,BBBB,AAAA every 4 cycles, no idle gap, o_owner 0,1,0.
//   4. i_hold=1 for 3 cycles mid-dwell -> that word shown 7 cycles total; no ready during hold even with valid pending.
//   5. rst asserted asynchronously mid-SHOW -> o_data=16'h0000 and o_busy=0 before the next edge; after release req1 alone is granted.
//   6. req1 raises valid then drops it before its window -> no transfer, o_data unchanged; N_REQ=1 build shows back-to-back grants to req0.

Source files
------------

// File: rtl/hex_display_sched_pkg.sv
// Shared definitions for the hex display scheduler: data width, FSM states
// and the owner-index width helper.
package hex_display_sched_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    // Width of an index into n requesters; a single requester still needs one bit.
    function automatic int own_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_display_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first valid request found when
// scanning upward from ptr (wrapping) wins. The caller owns the pointer.
module rr_arbiter
    import hex_display_sched_pkg::*;
#(
    parameter int N = 2,
    parameter int W = own_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    int   scanIdx;
    logic found;

    // Scan all requesters starting at ptr and grant only the first valid one.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        scanIdx = 0;
        for (int i = 0; i < N; i++) begin
            scanIdx = (int'(ptr) + i) % N;
            if (en && !found && req[scanIdx]) begin
                found        = 1'b1;
                gnt[scanIdx] = 1'b1;
                gnt_idx      = W'(scanIdx);
            end
        end
    end

endmodule

// File: rtl/hex_display_sched.sv
// Shares the 4-digit hex display among N_REQ requesters. Each accepted word
// stays on o_data for DWELL_CYCLES cycles (plus held cycles); grants rotate.
module hex_display_sched
    import hex_display_sched_pkg::*;
#(
    parameter int                N_REQ        = 2,
    parameter int                DWELL_W      = 24,
    parameter int                DWELL_CYCLES = 5_000_000,
    parameter logic [DATA_W-1:0] IDLE_VALUE   = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [DATA_W*N_REQ-1:0]    i_req_data,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic                       i_hold,
    output logic [DATA_W-1:0]          o_data,
    output logic [own_w(N_REQ)-1:0]    o_owner,
    output logic                       o_busy
);

    localparam int OWN_W = own_w(N_REQ);

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [OWN_W-1:0]   ptr_q, ptr_d;

    logic [N_REQ-1:0]   grant;
    logic [OWN_W-1:0]   grantIdx;
    logic               windowOpen;
    logic               transfer;

    // A new word may be accepted when idle, or in the last dwell cycle so words chain back-to-back.
    assign windowOpen = !rst && !i_hold && ((state_q == ST_IDLE) || (cnt_q == '0));

    rr_arbiter #(
        .N (N_REQ),
        .W (OWN_W)
    ) u_arb (
        .req     (i_req_valid),
        .ptr     (ptr_q),
        .en      (windowOpen),
        .gnt     (grant),
        .gnt_idx (grantIdx)
    );

    assign o_req_ready = grant;
    assign transfer    = |(grant & i_req_valid);
    assign o_data      = data_q;
    assign o_owner     = owner_q;
    assign o_busy      = (state_q == ST_SHOW);

    // Next-state: load on transfer, otherwise count the dwell down unless frozen by hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (transfer) begin
            state_d = ST_SHOW;
            cnt_d   = DWELL_W'(DWELL_CYCLES - 1);
            data_d  = i_req_data[DATA_W*int'(grantIdx) +: DATA_W];
            owner_d = grantIdx;
            ptr_d   = (int'(grantIdx) == N_REQ - 1) ? '0 : grantIdx + 1'b1;
        end else if (!i_hold && (state_q == ST_SHOW)) begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // State, dwell counter, shown word, owner and rotation pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= IDLE_VALUE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
